// File: rtl/cam_capture_pkg.sv
// ---------------------------------------------------------------------------
// cam_capture_pkg
// Shared types and constants for the camera capture packer:
//   - cap_state_t : capture FSM state encoding
//   - byte-lane geometry of the packed FIFO word
//   - DROP_CNT_WIDTH : width of the dropped-word counter
//   - place_byte() : positions one byte in its word lane for either byte order
// ---------------------------------------------------------------------------
package cam_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_ACTIVE     = 2'd2,
    ST_FLUSH      = 2'd3
  } cap_state_t;

  localparam int LANE_W         = 8;
  localparam int NUM_LANES      = 4;
  localparam int WORD_W         = LANE_W * NUM_LANES;
  localparam int DROP_CNT_WIDTH = 16;

  localparam logic [1:0] LAST_LANE = 2'd3;

  // order = 0: byte idx 0 lands in [7:0]; order = 1: byte idx 0 lands in [31:24].
  function automatic logic [WORD_W-1:0] place_byte(input logic [LANE_W-1:0] b,
                                                   input logic [1:0]        idx,
                                                   input logic              order);
    logic [1:0]        lane;
    logic [WORD_W-1:0] w;
    lane = order ? (LAST_LANE - idx) : idx;
    w    = '0;
    case (lane)
      2'd0:    w[7:0]   = b;
      2'd1:    w[15:8]  = b;
      2'd2:    w[23:16] = b;
      default: w[31:24] = b;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// ---------------------------------------------------------------------------
// cam_sync_edge
// Oversampling synchronizer for one asynchronous camera signal. Two flops
// (s1, s2) resolve metastability; s3 holds the previous synchronized value so
// edges can be detected in the WB clock domain.
// Ports:
//   i_clk   : system clock
//   i_rst   : asynchronous active-high reset
//   i_d     : raw asynchronous input
//   o_level : synchronized level (s2)
//   o_rise  : one-cycle pulse on a synchronized 0->1 transition
//   o_fall  : one-cycle pulse on a synchronized 1->0 transition
// ---------------------------------------------------------------------------
module cam_sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_s2 & ~r_s3;
  assign o_fall  = ~r_s2 & r_s3;

endmodule

// File: rtl/cam_capture_packer.sv
// ---------------------------------------------------------------------------
// cam_capture_packer
// Camera capture front-end. Oversamples PCLK/VSYNC/HREF/DAT, packs active-line
// bytes four at a time into 32-bit words and writes them to the capture FIFO.
// Reports completed frames, the line count of the last frame, and a sticky
// overflow flag plus a saturating count of words dropped on FIFO full.
//
// Ports:
//   WBs_CLK_i       : system clock (>= 3x PCLK)
//   WBs_RST_i       : asynchronous active-high reset
//   PCLK_i          : camera pixel clock, sampled as data
//   VSYNC_i         : high during vertical blanking
//   HREF_i          : high during active line bytes
//   CAM_DAT_i       : camera data byte
//   CAP_EN_i        : capture enable level
//   OVF_CLR_i       : one-cycle pulse clearing Overflow_o
//   FIFO_FULL_i     : downstream FIFO full
//   FIFO_WR_EN_o    : one-cycle FIFO write strobe
//   FIFO_WR_DAT_o   : packed word
//   Busy_o          : FSM is not IDLE
//   Overflow_o      : sticky, a word was dropped
//   Frame_Cnt_o     : completed frames (wraps)
//   Last_Line_Cnt_o : lines in the last completed frame
//   Drop_Cnt_o      : dropped words (saturates)
//
// state         | meaning
// ST_IDLE       | capture disabled
// ST_WAIT_FRAME | enabled, waiting for VSYNC fall (start of frame)
// ST_ACTIVE     | packing bytes and counting lines
// ST_FLUSH      | one cycle: push partial word, update frame/line counts
// ---------------------------------------------------------------------------
module cam_capture_packer
  import cam_capture_pkg::*;
#(
  parameter int LINE_CNT_WIDTH  = 12,
  parameter int FRAME_CNT_WIDTH = 16,
  parameter int BYTE_ORDER      = 0
) (
  input  logic                       WBs_CLK_i,
  input  logic                       WBs_RST_i,
  input  logic                       PCLK_i,
  input  logic                       VSYNC_i,
  input  logic                       HREF_i,
  input  logic [7:0]                 CAM_DAT_i,
  input  logic                       CAP_EN_i,
  input  logic                       OVF_CLR_i,
  input  logic                       FIFO_FULL_i,
  output logic                       FIFO_WR_EN_o,
  output logic [31:0]                FIFO_WR_DAT_o,
  output logic                       Busy_o,
  output logic                       Overflow_o,
  output logic [FRAME_CNT_WIDTH-1:0] Frame_Cnt_o,
  output logic [LINE_CNT_WIDTH-1:0]  Last_Line_Cnt_o,
  output logic [DROP_CNT_WIDTH-1:0]  Drop_Cnt_o
);

  localparam logic [LINE_CNT_WIDTH-1:0]  LINE_ONE  = LINE_CNT_WIDTH'(1);
  localparam logic [FRAME_CNT_WIDTH-1:0] FRAME_ONE = FRAME_CNT_WIDTH'(1);
  localparam logic [DROP_CNT_WIDTH-1:0]  DROP_ONE  = DROP_CNT_WIDTH'(1);
  localparam logic                       ORDER_MSB = (BYTE_ORDER != 0);

  logic w_pclk_lvl, w_pclk_rise, w_pclk_fall;
  logic w_vs_lvl,   w_vs_rise,   w_vs_fall;
  logic w_href_lvl, w_href_rise, w_href_fall;
  logic w_unused;

  logic [7:0] r_dat_s1;
  logic [7:0] r_dat_s2;

  cap_state_t                 r_state;
  logic                       r_busy;
  logic [1:0]                 r_byte_idx;
  logic [WORD_W-1:0]          r_word;
  logic [LINE_CNT_WIDTH-1:0]  r_line_cnt;
  logic [LINE_CNT_WIDTH-1:0]  r_last_line;
  logic [FRAME_CNT_WIDTH-1:0] r_frame_cnt;
  logic [DROP_CNT_WIDTH-1:0]  r_drop_cnt;
  logic                       r_ovf;
  logic                       r_wr_en;
  logic [WORD_W-1:0]          r_wr_dat;

  logic              w_capture;
  logic              w_flush_push;
  logic              w_push_req;
  logic [WORD_W-1:0] w_cap_word;
  logic [WORD_W-1:0] w_push_word;

  cam_sync_edge u_sync_pclk (
    .i_clk(WBs_CLK_i), .i_rst(WBs_RST_i), .i_d(PCLK_i),
    .o_level(w_pclk_lvl), .o_rise(w_pclk_rise), .o_fall(w_pclk_fall)
  );

  cam_sync_edge u_sync_vsync (
    .i_clk(WBs_CLK_i), .i_rst(WBs_RST_i), .i_d(VSYNC_i),
    .o_level(w_vs_lvl), .o_rise(w_vs_rise), .o_fall(w_vs_fall)
  );

  cam_sync_edge u_sync_href (
    .i_clk(WBs_CLK_i), .i_rst(WBs_RST_i), .i_d(HREF_i),
    .o_level(w_href_lvl), .o_rise(w_href_rise), .o_fall(w_href_fall)
  );

  assign w_unused = ^{w_pclk_lvl, w_pclk_fall, w_vs_lvl, w_href_rise};

  // Data only needs the same depth as PCLK s2 so the byte lines up with pclk_rise.
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      r_dat_s1 <= 8'h00;
      r_dat_s2 <= 8'h00;
    end else begin
      r_dat_s1 <= CAM_DAT_i;
      r_dat_s2 <= r_dat_s1;
    end
  end

  assign w_capture    = (r_state == ST_ACTIVE) && w_pclk_rise && w_href_lvl;
  assign w_flush_push = (r_state == ST_FLUSH) && (r_byte_idx != 2'd0);
  assign w_push_req   = (w_capture && (r_byte_idx == LAST_LANE)) || w_flush_push;
  // Lanes not yet written stay zero because r_word is cleared after every push.
  assign w_cap_word   = r_word | place_byte(r_dat_s2, r_byte_idx, ORDER_MSB);
  assign w_push_word  = w_flush_push ? r_word : w_cap_word;

  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_byte_idx  <= 2'd0;
      r_word      <= '0;
      r_line_cnt  <= '0;
      r_last_line <= '0;
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
      r_ovf       <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_dat    <= '0;
    end else begin
      r_wr_en <= 1'b0;

      if (w_push_req) begin
        if (FIFO_FULL_i) begin
          if (!(&r_drop_cnt)) r_drop_cnt <= r_drop_cnt + DROP_ONE;
        end else begin
          r_wr_en  <= 1'b1;
          r_wr_dat <= w_push_word;
        end
      end

      // A drop in the same cycle as a clear request keeps the flag set.
      if (w_push_req && FIFO_FULL_i) r_ovf <= 1'b1;
      else if (OVF_CLR_i)            r_ovf <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (CAP_EN_i) begin
            r_state <= ST_WAIT_FRAME;
            r_busy  <= 1'b1;
          end
        end
        ST_WAIT_FRAME: begin
          if (!CAP_EN_i) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_vs_fall) begin
            r_state <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          // CAP_EN_i is ignored here: a started frame always runs to FLUSH.
          if (w_capture) begin
            r_byte_idx <= r_byte_idx + 2'd1;
            r_word     <= (r_byte_idx == LAST_LANE) ? '0 : w_cap_word;
          end
          if (w_href_fall && !(&r_line_cnt)) r_line_cnt <= r_line_cnt + LINE_ONE;
          if (w_vs_rise) r_state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          r_byte_idx  <= 2'd0;
          r_word      <= '0;
          r_last_line <= r_line_cnt;
          r_line_cnt  <= '0;
          r_frame_cnt <= r_frame_cnt + FRAME_ONE;
          if (CAP_EN_i) begin
            r_state <= ST_WAIT_FRAME;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign FIFO_WR_EN_o    = r_wr_en;
  assign FIFO_WR_DAT_o   = r_wr_dat;
  assign Busy_o          = r_busy;
  assign Overflow_o      = r_ovf;
  assign Frame_Cnt_o     = r_frame_cnt;
  assign Last_Line_Cnt_o = r_last_line;
  assign Drop_Cnt_o      = r_drop_cnt;

endmodule
